// File: rtl/receive_checker.sv
// receive_checker: registers transmit words, checks BCD and count continuity, tracks lock; RX_CHECK_STATS_EN adds err_count
module receive_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter bit ALLOW_REPEAT = 1'b1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        rx_valid,
  input  logic [11:0] rx_word,
  output logic        out_valid,
  output logic [5:0]  bin_out,
  output logic [2:0]  bcd_tens,
  output logic [3:0]  bcd_units,
  output logic        word_ok,
  output logic        seq_ok,
  output logic        locked,
  output logic        err_sticky,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;
  state_t      state, next_state;
  logic        s1_valid;
  logic [11:0] s1_word;
  logic [5:0]  prev_bin, bin;
  logic [3:0]  run, next_run, run_inc;
  logic [5:0]  exp_conv;
  logic        w_ok, s_ok, good;
  always_comb begin
    bin        = s1_word[11:6];
    exp_conv   = {3'(bin / 6'd10), 3'((bin % 6'd10) >> 1)};
    w_ok       = s1_word[5:0] == exp_conv;
    s_ok       = state == HUNT || bin == prev_bin + 6'd1 || (ALLOW_REPEAT && bin == prev_bin);
    good       = w_ok & s_ok;
    run_inc    = run + 4'd1;
    next_state = state == HUNT   ? (w_ok ? TRACK : HUNT) :
                 state == TRACK  ? (good && run_inc >= 4'(LOCK_COUNT) ? LOCKED : TRACK) :
                 good ? LOCKED : TRACK;
    next_run   = state == HUNT   ? (w_ok ? 4'd1 : 4'd0) :
                 state == TRACK  ? (good ? run_inc : 4'd0) :
                 good ? run : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_valid   <= 1'b0;
      s1_word    <= '0;
      state      <= HUNT;
      run        <= '0;
      prev_bin   <= '0;
      out_valid  <= 1'b0;
      bin_out    <= '0;
      bcd_tens   <= '0;
      bcd_units  <= '0;
      word_ok    <= 1'b0;
      seq_ok     <= 1'b0;
      locked     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      s1_valid  <= rx_valid;
      out_valid <= s1_valid;
      if (rx_valid) s1_word <= rx_word;
      if (s1_valid) begin
        state      <= next_state;
        run        <= next_run;
        prev_bin   <= bin;
        bin_out    <= bin;
        bcd_tens   <= s1_word[5:3];
        bcd_units  <= {s1_word[2:0], s1_word[6]};
        word_ok    <= w_ok;
        seq_ok     <= s_ok;
        locked     <= next_state == LOCKED;
        err_sticky <= err_sticky | (state == LOCKED && !good);
      end
    end
  end
`ifdef RX_CHECK_STATS_EN
  always_ff @(posedge clk) begin
    if (clear) err_count <= '0;
    else if (s1_valid && !good && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_receive_checker.sv
// tb_receive_checker: directed tests for receive_checker, with a second instance built with ALLOW_REPEAT=0
module tb_receive_checker;
  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        rx_valid = 1'b0;
  logic [11:0] rx_word = '0;
  logic        out_valid, word_ok, seq_ok, locked, err_sticky;
  logic [5:0]  bin_out;
  logic [2:0]  bcd_tens;
  logic [3:0]  bcd_units;
  logic [7:0]  err_count;
  logic        nr_out_valid, nr_word_ok, nr_seq_ok, nr_locked, nr_err_sticky;
  logic [5:0]  nr_bin_out;
  logic [2:0]  nr_bcd_tens;
  logic [3:0]  nr_bcd_units;
  logic [7:0]  nr_err_count;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  receive_checker dut (
    .clk(clk), .clear(clear), .rx_valid(rx_valid), .rx_word(rx_word),
    .out_valid(out_valid), .bin_out(bin_out), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
    .word_ok(word_ok), .seq_ok(seq_ok), .locked(locked), .err_sticky(err_sticky), .err_count(err_count)
  );
  receive_checker #(.LOCK_COUNT(4), .ALLOW_REPEAT(1'b0)) dut_nr (
    .clk(clk), .clear(clear), .rx_valid(rx_valid), .rx_word(rx_word),
    .out_valid(nr_out_valid), .bin_out(nr_bin_out), .bcd_tens(nr_bcd_tens), .bcd_units(nr_bcd_units),
    .word_ok(nr_word_ok), .seq_ok(nr_seq_ok), .locked(nr_locked), .err_sticky(nr_err_sticky), .err_count(nr_err_count)
  );
`ifdef RX_CHECK_STATS_EN
  localparam logic [7:0] ERR_ONE = 8'd1;
`else
  localparam logic [7:0] ERR_ONE = 8'd0;
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  task automatic send_one(input logic [11:0] w);
    rx_valid = 1'b1;
    rx_word  = w;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    clear = 1'b1;
    rx_valid = 1'b1;
    rx_word = 12'h95B;
    tick();
    tick();
    rx_valid = 1'b0;
    clear = 1'b0;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0h exp=0", locked); end
    if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err_sticky got=%0h exp=0", err_sticky); end
    if (bin_out !== 6'd0) begin bad++; $display("FAIL reset_bin_out got=%0h exp=0", bin_out); end
    if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count got=%0h exp=0", err_count); end
  endtask
  task automatic test_back_to_back();
    rx_valid = 1'b1;
    rx_word = 12'h000;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid got=%0h exp=0", out_valid); end
    rx_word = 12'h040;
    tick();
    rx_valid = 1'b0;
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_w0_valid got=%0h exp=1", out_valid); end
    if (bin_out !== 6'd0) begin bad++; $display("FAIL b2b_w0_bin got=%0h exp=0", bin_out); end
    if (word_ok !== 1'b1) begin bad++; $display("FAIL b2b_w0_word_ok got=%0h exp=1", word_ok); end
    if (seq_ok !== 1'b1) begin bad++; $display("FAIL b2b_w0_seq_ok got=%0h exp=1", seq_ok); end
    tick();
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_w1_valid got=%0h exp=1", out_valid); end
    if (bin_out !== 6'd1) begin bad++; $display("FAIL b2b_w1_bin got=%0h exp=1", bin_out); end
    if (word_ok !== 1'b1) begin bad++; $display("FAIL b2b_w1_word_ok got=%0h exp=1", word_ok); end
    if (seq_ok !== 1'b1) begin bad++; $display("FAIL b2b_w1_seq_ok got=%0h exp=1", seq_ok); end
    tick();
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0h exp=0", out_valid); end
    if (bin_out !== 6'd1) begin bad++; $display("FAIL idle_hold_bin got=%0h exp=1", bin_out); end
  endtask
  task automatic test_bcd();
    send_one(12'h95B);
    total += 5;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bcd37_valid got=%0h exp=1", out_valid); end
    if (bcd_tens !== 3'd3) begin bad++; $display("FAIL bcd37_tens got=%0h exp=3", bcd_tens); end
    if (bcd_units !== 4'd7) begin bad++; $display("FAIL bcd37_units got=%0h exp=7", bcd_units); end
    if (word_ok !== 1'b1) begin bad++; $display("FAIL bcd37_word_ok got=%0h exp=1", word_ok); end
    if (seq_ok !== 1'b0) begin bad++; $display("FAIL bcd37_seq_ok got=%0h exp=0", seq_ok); end
    send_one(12'h95A);
    total += 4;
    if (word_ok !== 1'b0) begin bad++; $display("FAIL corrupt_word_ok got=%0h exp=0", word_ok); end
    if (bcd_units !== 4'd5) begin bad++; $display("FAIL corrupt_units got=%0h exp=5", bcd_units); end
    if (seq_ok !== 1'b1) begin bad++; $display("FAIL corrupt_repeat_seq got=%0h exp=1", seq_ok); end
    if (nr_seq_ok !== 1'b0) begin bad++; $display("FAIL corrupt_norepeat_seq got=%0h exp=0", nr_seq_ok); end
  endtask
  task automatic test_lock();
    logic [11:0] words [5] = '{12'hF30, 12'hF70, 12'hFB1, 12'hFF1, 12'h000};
    logic [4:0]  exp_lock = 5'b11000;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      send_one(words[i]);
      total += 3;
      if (locked !== exp_lock[i]) begin bad++; $display("FAIL lock_step%0d got=%0h exp=%0h", i, locked, exp_lock[i]); end
      if (word_ok !== 1'b1) begin bad++; $display("FAIL lock_word_ok%0d got=%0h exp=1", i, word_ok); end
      if (seq_ok !== 1'b1) begin bad++; $display("FAIL lock_seq_ok%0d got=%0h exp=1", i, seq_ok); end
    end
  endtask
  task automatic test_error();
    send_one(12'h040);
    send_one(12'h081);
    send_one(12'h0C1);
    total += 2;
    if (locked !== 1'b1) begin bad++; $display("FAIL err_pre_locked got=%0h exp=1", locked); end
    if (err_sticky !== 1'b0) begin bad++; $display("FAIL err_pre_sticky got=%0h exp=0", err_sticky); end
    send_one(12'h142);
    total += 5;
    if (seq_ok !== 1'b0) begin bad++; $display("FAIL err_seq_ok got=%0h exp=0", seq_ok); end
    if (word_ok !== 1'b1) begin bad++; $display("FAIL err_word_ok got=%0h exp=1", word_ok); end
    if (locked !== 1'b0) begin bad++; $display("FAIL err_locked got=%0h exp=0", locked); end
    if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0h exp=1", err_sticky); end
    if (err_count !== ERR_ONE) begin bad++; $display("FAIL err_count got=%0h exp=%0h", err_count, ERR_ONE); end
    send_one(12'h183);
    total += 3;
    if (seq_ok !== 1'b1) begin bad++; $display("FAIL resync_seq_ok got=%0h exp=1", seq_ok); end
    if (err_sticky !== 1'b1) begin bad++; $display("FAIL resync_sticky got=%0h exp=1", err_sticky); end
    if (locked !== 1'b0) begin bad++; $display("FAIL resync_locked got=%0h exp=0", locked); end
  endtask
  task automatic test_repeat();
    do_clear();
    send_one(12'h244);
    total += 2;
    if (seq_ok !== 1'b1) begin bad++; $display("FAIL rep1_seq_ok got=%0h exp=1", seq_ok); end
    if (nr_seq_ok !== 1'b1) begin bad++; $display("FAIL rep1_nr_seq_ok got=%0h exp=1", nr_seq_ok); end
    send_one(12'h244);
    total += 3;
    if (seq_ok !== 1'b1) begin bad++; $display("FAIL rep2_seq_ok got=%0h exp=1", seq_ok); end
    if (nr_seq_ok !== 1'b0) begin bad++; $display("FAIL rep2_nr_seq_ok got=%0h exp=0", nr_seq_ok); end
    if (nr_word_ok !== 1'b1) begin bad++; $display("FAIL rep2_nr_word_ok got=%0h exp=1", nr_word_ok); end
  endtask
  task automatic test_clear_inflight();
    send_one(12'h288);
    send_one(12'h2C8);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL cif_pre_locked got=%0h exp=1", locked); end
    rx_valid = 1'b1;
    rx_word = 12'h309;
    tick();
    rx_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL cif_valid got=%0h exp=0", out_valid); end
    if (locked !== 1'b0) begin bad++; $display("FAIL cif_locked got=%0h exp=0", locked); end
    if (bin_out !== 6'd0) begin bad++; $display("FAIL cif_bin got=%0h exp=0", bin_out); end
    if (word_ok !== 1'b0) begin bad++; $display("FAIL cif_word_ok got=%0h exp=0", word_ok); end
    if (bcd_tens !== 3'd0) begin bad++; $display("FAIL cif_tens got=%0h exp=0", bcd_tens); end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL cif_late_valid got=%0h exp=0", out_valid); end
    send_one(12'h309);
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL cif_next_valid got=%0h exp=1", out_valid); end
    if (word_ok !== 1'b1) begin bad++; $display("FAIL cif_next_word_ok got=%0h exp=1", word_ok); end
    if (locked !== 1'b0) begin bad++; $display("FAIL cif_next_locked got=%0h exp=0", locked); end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_bcd();
    test_lock();
    test_error();
    test_repeat();
    test_clear_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
